// File: rtl/dmem_pipe.sv
// dmem_pipe: pipelined, byte-addressable data memory for the MEM stage.
// Big-endian lanes, valid/ready request port, RD_LAT-cycle in-order responses,
// and a post-reset sweep that clears the array before requests are accepted.
// Optional feature macro: DMEM_ERR_EN adds rsp_err and drops/zeroes
// out-of-range or misaligned accesses instead of aligning them down.
module dmem_pipe #(
  parameter int WORD_LEN    = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int BASE_ADDR   = 1024,
  parameter int RD_LAT      = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [WORD_LEN/8-1:0] req_be,
  input  logic [WORD_LEN-1:0]   req_addr,
  input  logic [WORD_LEN-1:0]   req_wdata,
  output logic                  rsp_valid,
  output logic [WORD_LEN-1:0]   rsp_rdata,
  output logic                  init_done
`ifdef DMEM_ERR_EN
  ,
  output logic                  rsp_err
`endif
);

  localparam int NB  = WORD_LEN / 8;
  localparam int OFS = $clog2(NB);
  localparam int AW  = $clog2(DEPTH_WORDS);

  // Extra top bit so addresses below the base show up as huge offsets, not wrapped ones
  localparam logic [WORD_LEN:0] BASE_EXT = (WORD_LEN+1)'(BASE_ADDR);
  localparam logic [WORD_LEN:0] SPAN     = (WORD_LEN+1)'(DEPTH_WORDS * NB);

  typedef enum logic {INIT, RUN} state_t;

  state_t              state;
  logic [AW-1:0]       init_cnt;
  logic [WORD_LEN-1:0] mem [DEPTH_WORDS];

  logic                accept;
  logic [WORD_LEN:0]   offset;
  logic                in_range;
  logic [AW-1:0]       idx;
  logic                ok;

  logic [RD_LAT-1:0]   vld;
  logic [WORD_LEN-1:0] dat [RD_LAT];

  assign accept   = req_valid & req_ready;
  assign offset   = {1'b0, req_addr} - BASE_EXT;
  assign in_range = offset < SPAN;
  assign idx      = offset[OFS+AW-1:OFS];

`ifdef DMEM_ERR_EN
  localparam logic [WORD_LEN-1:0] LOW_MASK = WORD_LEN'(NB - 1);
  logic              misaligned;
  logic [RD_LAT-1:0] err;

  assign misaligned = (req_addr & LOW_MASK) != '0;
  assign ok         = in_range & ~misaligned;
  assign rsp_err    = err[RD_LAT-1];
`else
  assign ok         = in_range;
`endif

  // Init sweep controller: clears one word per cycle, then opens the request port for good
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= INIT;
      init_cnt  <= '0;
      req_ready <= 1'b0;
      init_done <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          init_cnt <= init_cnt + AW'(1);
          if (init_cnt == AW'(DEPTH_WORDS - 1)) begin
            state     <= RUN;
            req_ready <= 1'b1;
            init_done <= 1'b1;
          end
        end
        RUN: begin
          req_ready <= 1'b1;
          init_done <= 1'b1;
        end
        default: state <= INIT;
      endcase
    end
  end

  // Storage array: zeroed by the sweep, then byte-lane writes from accepted in-range requests
  always_ff @(posedge clk) begin
    if (state == INIT) begin
      mem[init_cnt] <= '0;
    end else if (accept && req_we && ok) begin
      for (int k = 0; k < NB; k++) begin
        if (req_be[k]) mem[idx][8*k +: 8] <= req_wdata[8*k +: 8];
      end
    end
  end

  // Response pipeline: stage 0 samples the array at the accept edge, later stages only delay
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LAT; i++) begin
        vld[i] <= 1'b0;
        dat[i] <= '0;
      end
`ifdef DMEM_ERR_EN
      err <= '0;
`endif
    end else begin
      vld[0] <= accept;
      dat[0] <= (accept && !req_we && ok) ? mem[idx] : '0;
`ifdef DMEM_ERR_EN
      err[0] <= accept & ~ok;
`endif
      for (int i = 1; i < RD_LAT; i++) begin
        vld[i] <= vld[i-1];
        dat[i] <= dat[i-1];
`ifdef DMEM_ERR_EN
        err[i] <= err[i-1];
`endif
      end
    end
  end

  assign rsp_valid = vld[RD_LAT-1];
  assign rsp_rdata = dat[RD_LAT-1];

endmodule

// File: tb/tb_dmem_pipe.sv
// tb_dmem_pipe: directed bench driving two dmem_pipe instances (RD_LAT 1 and 3)
// with an identical request stream; each instance has its own expected-response queue.
module tb_dmem_pipe;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_we;
  logic [3:0]  req_be;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        req_ready1, rsp_valid1, init_done1;
  logic [31:0] rsp_rdata1;
  logic        req_ready3, rsp_valid3, init_done3;
  logic [31:0] rsp_rdata3;
`ifdef DMEM_ERR_EN
  logic        rsp_err1, rsp_err3;
  localparam logic ERR_ON = 1'b1;
`else
  localparam logic ERR_ON = 1'b0;
`endif

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t q1[$];
  exp_t q3[$];
  int   cyc;
  int   checkCount;
  int   passCount;

  dmem_pipe #(.RD_LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready1),
    .req_we(req_we), .req_be(req_be), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid1), .rsp_rdata(rsp_rdata1), .init_done(init_done1)
`ifdef DMEM_ERR_EN
    , .rsp_err(rsp_err1)
`endif
  );

  dmem_pipe #(.RD_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready3),
    .req_we(req_we), .req_be(req_be), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid3), .rsp_rdata(rsp_rdata3), .init_done(init_done3)
`ifdef DMEM_ERR_EN
    , .rsp_err(rsp_err3)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs === exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  // Response monitor for the RD_LAT=1 instance, sampled just after the active edge
  always @(posedge clk) begin
    #1;
    if (rsp_valid1) begin
      if (q1.size() == 0) begin
        checkOutput("unexpected_rsp1", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q1.pop_front();
        checkOutput("rdata1", rsp_rdata1, e.data);
        checkOutput("latency1", 32'(cyc), 32'(e.cyc));
`ifdef DMEM_ERR_EN
        checkOutput("err1", {31'd0, rsp_err1}, {31'd0, e.err});
`endif
      end
    end
  end

  // Response monitor for the RD_LAT=3 instance
  always @(posedge clk) begin
    #1;
    if (rsp_valid3) begin
      if (q3.size() == 0) begin
        checkOutput("unexpected_rsp3", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q3.pop_front();
        checkOutput("rdata3", rsp_rdata3, e.data);
        checkOutput("latency3", 32'(cyc), 32'(e.cyc));
`ifdef DMEM_ERR_EN
        checkOutput("err3", {31'd0, rsp_err3}, {31'd0, e.err});
`endif
      end
    end
  end

  task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] be, input logic [31:0] expData, input logic expErr);
    exp_t e;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    e.data = expData;
    e.err  = expErr;
    e.cyc  = cyc + 1;
    q1.push_back(e);
    e.cyc  = cyc + 3;
    q3.push_back(e);
    @(posedge clk);
  endtask

  task automatic writeReq(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] be,
                          input logic expErr);
    applyStimulus(1'b1, addr, wdata, be, 32'h0, expErr);
  endtask

  task automatic readReq(input logic [31:0] addr, input logic [31:0] expData, input logic expErr);
    applyStimulus(1'b0, addr, 32'h0, 4'h0, expData, expErr);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    req_valid = 1'b0;
    req_we    = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_ready"}, {30'd0, req_ready1, req_ready3}, 32'd0);
    checkOutput({tag, "_valid"}, {30'd0, rsp_valid1, rsp_valid3}, 32'd0);
    checkOutput({tag, "_rdata1"}, rsp_rdata1, 32'd0);
    checkOutput({tag, "_rdata3"}, rsp_rdata3, 32'd0);
    checkOutput({tag, "_done"}, {30'd0, init_done1, init_done3}, 32'd0);
`ifdef DMEM_ERR_EN
    checkOutput({tag, "_err"}, {30'd0, rsp_err1, rsp_err3}, 32'd0);
`endif
  endtask

  // Counts edges after reset release until the port opens; a missing open counts as a failure
  task automatic waitInit();
    int n;
    n = 0;
    while (n < 400) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 255) checkOutput("ready_before_end", {31'd0, req_ready1}, 32'd0);
      if (req_ready1) break;
    end
    checkOutput("init_cycles", 32'(n), 32'd256);
    checkOutput("init_done", {30'd0, init_done1, init_done3}, 32'd3);
    checkOutput("ready3", {31'd0, req_ready3}, 32'd1);
  endtask

  initial begin
    cyc        = 0;
    checkCount = 0;
    passCount  = 0;
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_be     = 4'h0;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;

    // Reset state and init sweep
    repeat (3) @(negedge clk);
    checkResetOutputs("reset");
    rst_n = 1'b1;
    waitInit();
    readReq(32'd1024, 32'h0, 1'b0);
    readReq(32'd1028, 32'h0, 1'b0);
    readReq(32'd2044, 32'h0, 1'b0);
    idle(1);

    // Full-word write then read-after-write
    writeReq(32'd1028, 32'hDEADBEEF, 4'hF, 1'b0);
    readReq(32'd1028, 32'hDEADBEEF, 1'b0);
    idle(1);

    // Byte strobes, big-endian lanes
    writeReq(32'd1028, 32'h11223344, 4'b0101, 1'b0);
    readReq(32'd1028, 32'hDE22BE44, 1'b0);
    writeReq(32'd1028, 32'h99999999, 4'h0, 1'b0);
    readReq(32'd1028, 32'hDE22BE44, 1'b0);
    idle(1);

    // Out-of-range and misaligned accesses
    writeReq(32'd16, 32'h12345678, 4'hF, 1'b1);
    writeReq(32'd2048, 32'h12345678, 4'hF, 1'b1);
    readReq(32'd16, 32'h0, 1'b1);
    readReq(32'd2048, 32'h0, 1'b1);
    readReq(32'd1020, 32'h0, 1'b1);
    readReq(32'd1024, 32'h0, 1'b0);
    readReq(32'd1029, ERR_ON ? 32'h0 : 32'hDE22BE44, ERR_ON);
    writeReq(32'd1030, 32'hFFFFFFFF, 4'hF, ERR_ON);
    readReq(32'd1028, ERR_ON ? 32'hDE22BE44 : 32'hFFFFFFFF, 1'b0);
    idle(1);

    // Back-to-back writes then reads, plus the last in-range word
    for (int i = 0; i < 8; i++) writeReq(32'(1024 + 4*i), 32'hC0DE0000 + 32'(i), 4'hF, 1'b0);
    writeReq(32'd2044, 32'hCAFEF00D, 4'hF, 1'b0);
    for (int i = 0; i < 8; i++) readReq(32'(1024 + 4*i), 32'hC0DE0000 + 32'(i), 1'b0);
    readReq(32'd2044, 32'hCAFEF00D, 1'b0);
    idle(5);
    checkOutput("drain1", 32'(q1.size()), 32'd0);
    checkOutput("drain3", 32'(q3.size()), 32'd0);

    // Reset with reads in flight
    readReq(32'd1024, 32'hC0DE0000, 1'b0);
    readReq(32'd1028, 32'hC0DE0001, 1'b0);
    readReq(32'd1032, 32'hC0DE0002, 1'b0);
    @(negedge clk);
    req_valid = 1'b0;
    rst_n     = 1'b0;
    #1;
    checkResetOutputs("midreset");
    q1.delete();
    q3.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    waitInit();
    readReq(32'd1028, 32'h0, 1'b0);
    readReq(32'd2044, 32'h0, 1'b0);
    readReq(32'd1052, 32'h0, 1'b0);
    idle(6);
    checkOutput("final_drain1", 32'(q1.size()), 32'd0);
    checkOutput("final_drain3", 32'(q3.size()), 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/dmem_pipe.md
Name: dmem_pipe

Overview:
- Parametrised, pipelined, byte-addressable data memory for the MIPS pipelined CPU's MEM stage.
- Next generation of the fixed 32-bit data memory. Adds:
  - configurable word width, depth, base address and read latency;
  - byte-lane write strobes;
  - valid/ready request handshake with in-order responses;
  - self-clearing init sweep after reset.
- Big-endian byte order: the lowest byte address maps to the MSB lane.

Parameters:
- WORD_LEN, 32, data and address width in bits; multiple of 8; power of two.
- DEPTH_WORDS, 256, number of words in the array; power of two.
- BASE_ADDR, 1024, first byte address backed by the array; multiple of WORD_LEN/8.
- RD_LAT, 1, cycles from request acceptance to rsp_valid; legal range 1..4.

Ports:
- clk, input, 1, clock; all state updates on rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- req_valid, input, 1, request present.
- req_ready, output, 1, block can accept a request this cycle.
- req_we, input, 1, 1 = write, 0 = read.
- req_be, input, WORD_LEN/8, byte write strobes; bit k enables bits [8k+7:8k].
- req_addr, input, WORD_LEN, byte address.
- req_wdata, input, WORD_LEN, write data.
- rsp_valid, output, 1, response valid (one-cycle pulse per request).
- rsp_rdata, output, WORD_LEN, read data; 0 for writes.
- init_done, output, 1, high once the post-reset clear sweep has completed.
- rsp_err, output, 1, access error flag (present only with DMEM_ERR_EN).

Behaviour:
- Reset: asynchronous and active-low, as already decided.
  - rst_n low clears state to INIT, the init counter, and all latency-pipeline valid bits.
  - While reset is asserted and in INIT: req_ready = 0, rsp_valid = 0, rsp_rdata = 0, init_done = 0, rsp_err = 0.
  - Reset mid-operation discards in-flight responses; no rsp_valid follows reset release until a new request is accepted.
- FSM states:
  - INIT:
    - Writes 0 to word index init_cnt each cycle, init_cnt = 0..DEPTH_WORDS-1.
    - After the write of index DEPTH_WORDS-1, goes to RUN.
    - The sweep takes exactly DEPTH_WORDS cycles after reset release.
  - RUN:
    - init_done = 1 and req_ready = 1 every cycle; no backpressure.
    - Only reset leaves RUN.
- Acceptance: a request is accepted on a rising edge with req_valid & req_ready. At most one request per cycle; every cycle may accept one.
- Address decode:
  - Offset = req_addr - BASE_ADDR.
  - Word index = offset >> log2(WORD_LEN/8); low address bits are ignored (aligned down).
  - In range iff BASE_ADDR <= req_addr < BASE_ADDR + DEPTH_WORDS*WORD_LEN/8.
- Byte lanes: lane WORD_LEN/8-1 (MSBs) holds byte offset 0 within the word.
- Write:
  - Only lanes with req_be[k] = 1 are updated, in the accept edge.
  - An out-of-range write is dropped and the array is unchanged.
  - A write with req_be = 0 is a no-op that still produces a response.
- Read:
  - The array is sampled at the accept edge; the data travels RD_LAT-1 further pipeline stages.
  - An out-of-range read returns 0.
- Response:
  - Every accepted request produces exactly one rsp_valid pulse RD_LAT cycles after acceptance (RD_LAT = 1: the cycle after the accept edge).
  - Responses are in order.
  - rsp_rdata is 0 for writes, and 0 whenever rsp_valid = 0.
- Hazards:
  - A read accepted the cycle after a write to the same word returns the new data.
  - No same-cycle read/write collision is possible because there is one request per cycle.
- Arithmetic: the address subtraction is done in WORD_LEN+1 bits so addresses below BASE_ADDR are detected without wrap-around.

Optional Feature:
- Macro: DMEM_ERR_EN.
- When defined:
  - rsp_err port exists.
  - rsp_err is asserted with rsp_valid when the request was out of range, or misaligned (req_addr low log2(WORD_LEN/8) bits nonzero).
  - Misaligned writes are dropped.
  - Misaligned reads return 0.
- When undefined:
  - Port absent.
  - Misaligned addresses are silently aligned down and accessed normally.
  - Out-of-range accesses behave as above without a flag.

Test Plan:
1. Init sweep: release rst_n at cycle 0 -> req_ready = 0 and init_done = 0 for 256 cycles, both 1 at cycle 256; a read of any address in 1024..2047 returns 0x00000000.
2. Full write and read:
   - Write 0xDEADBEEF to 1028 with be = 4'hF, then a read of 1028 the next cycle -> rsp_rdata = 0xDEADBEEF exactly RD_LAT cycles after the read is accepted.
   - Rerun with RD_LAT = 3 -> the same data with 3-cycle latency.
3. Byte strobes and endianness: after test 2, write 0x11223344 to 1028 with be = 4'b0101 -> read returns 0xDE22BE44.
4. Out of range:
   - Write 0x12345678 to address 16, then to 2048 -> array unchanged; reads of both return 0.
   - With DMEM_ERR_EN: rsp_err = 1 on all four responses.
5. Back-to-back pipelining: accept 8 consecutive reads of addresses 1024, 1028, ..., 1052 with no gaps -> 8 consecutive rsp_valid pulses in order with the previously written data.
6. Reset mid-stream: assert rst_n low while 3 reads are in flight (RD_LAT = 3) -> rsp_valid drops immediately, no stale response after release, the sweep reruns, and the array reads 0.
